// File: rtl/carousel_ingress_sched.sv
// carousel_ingress_sched: round-robin ingress scheduler feeding a multi-slot carousel
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready upstream handshake;
//   slot_data/slot_valid/slot_ready per-slot ingest; mon_valid/mon_ready dispense monitor;
//   drain_req/drain_done drain handshake; busy, occupancy, err_underflow, ingest_count status.
// Optional: define CAROUSEL_SCHED_STATS_EN to enable the saturating ingest_count counter.
module carousel_ingress_sched #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH-1:0]                 slot_data [BUFFER_SIZE],
    output logic [BUFFER_SIZE-1:0]           slot_valid,
    input  logic [BUFFER_SIZE-1:0]           slot_ready,
    input  logic [BUFFER_SIZE-1:0]           mon_valid,
    input  logic [BUFFER_SIZE-1:0]           mon_ready,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic                             busy,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy,
    output logic                             err_underflow,
    output logic [15:0]                      ingest_count
);
    localparam int OW = $clog2(BUFFER_SIZE+1);
    localparam int SW = OW + 1;
    localparam int PW = $clog2(BUFFER_SIZE);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state, state_next;
    logic [PW-1:0] rr_ptr, sel, sel_hi, sel_lo;
    logic hi_found, accept, underflow;
    logic [SW-1:0] disp, occ_sum;
    logic [OW-1:0] occ_next;
    for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_bcast
        assign slot_data[i] = in_data;
    end
    // Cyclic search from rr_ptr: prefer the lowest ready slot at or above rr_ptr,
    // otherwise wrap to the lowest ready slot overall.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        hi_found = 1'b0;
        disp = '0;
        for (int j = BUFFER_SIZE-1; j >= 0; j--) begin
            if (slot_ready[j]) sel_lo = PW'(j);
            if (slot_ready[j] && PW'(j) >= rr_ptr) begin
                sel_hi = PW'(j);
                hi_found = 1'b1;
            end
            disp = disp + SW'(mon_valid[j] & mon_ready[j]);
        end
        sel = hi_found ? sel_hi : sel_lo;
    end
    assign in_ready   = state == RUN && |slot_ready && occupancy < OW'(BUFFER_SIZE);
    assign accept     = in_valid && in_ready;
    assign slot_valid = accept ? BUFFER_SIZE'(1) << sel : '0;
    assign occ_sum    = SW'(occupancy) + SW'(accept);
    assign underflow  = occ_sum < disp;
    assign occ_next   = underflow ? '0 : OW'(occ_sum - disp);
    assign drain_done = state == DONE;
    assign busy       = state != RUN || occupancy != '0;
    always_comb begin
        state_next = state == RUN   ? (drain_req ? DRAIN : RUN) :
                     state == DRAIN ? (occ_next == '0 ? DONE : DRAIN) : RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            rr_ptr        <= '0;
            occupancy     <= '0;
            err_underflow <= 1'b0;
        end else begin
            state     <= state_next;
            occupancy <= occ_next;
            if (accept) rr_ptr <= sel == PW'(BUFFER_SIZE-1) ? '0 : sel + 1'b1;
            if (underflow) err_underflow <= 1'b1;
        end
    end
`ifdef CAROUSEL_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) ingest_count <= '0;
        else if (accept && ingest_count != 16'hFFFF) ingest_count <= ingest_count + 16'd1;
    end
`else
    assign ingest_count = 16'd0;
`endif
endmodule

// File: tb/tb_carousel_ingress_sched.sv
// tb_carousel_ingress_sched: randomized and directed checks against a behavioural model
module tb_carousel_ingress_sched;
    localparam int W = 8, N = 3, OW = $clog2(N+1);
    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] in_data;
    logic in_valid, in_ready;
    logic [W-1:0] slot_data [N];
    logic [N-1:0] slot_valid, slot_ready, mon_valid, mon_ready;
    logic drain_req, drain_done, busy, err_underflow;
    logic [OW-1:0] occupancy;
    logic [15:0] ingest_count;
    int checks = 0, failures = 0;
    int m_mode = 0, m_rr = 0, m_occ = 0, m_cnt = 0;
    bit m_err = 0;

    always #5 clk = ~clk;

    carousel_ingress_sched #(.WIDTH(W), .BUFFER_SIZE(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .slot_data(slot_data), .slot_valid(slot_valid), .slot_ready(slot_ready),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .drain_req(drain_req),
        .drain_done(drain_done), .busy(busy), .occupancy(occupancy),
        .err_underflow(err_underflow), .ingest_count(ingest_count)
    );

    // Model: mode 0 = running, 1 = draining, 2 = drain finished.
    function automatic int m_sel();
        for (int k = 0; k < N; k++) if (slot_ready[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic bit m_ready();
        return m_mode == 0 && slot_ready != 0 && m_occ < N;
    endfunction

    function automatic logic [N-1:0] m_valid();
        logic [N-1:0] v = '0;
        if (in_valid && m_ready()) v[m_sel()] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        bit acc = in_valid && m_ready();
        int s = m_sel();
        int t = m_occ + int'(acc) - $countones(mon_valid & mon_ready);
        int nocc = t < 0 ? 0 : t;
        @(posedge clk);
        #1;
        if (rst) begin
            m_mode = 0; m_rr = 0; m_occ = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (m_mode == 0) m_mode = drain_req ? 1 : 0;
            else if (m_mode == 1) m_mode = nocc == 0 ? 2 : 1;
            else m_mode = 0;
            if (acc) m_rr = (s + 1) % N;
            if (t < 0) m_err = 1;
            m_occ = nocc;
`ifdef CAROUSEL_SCHED_STATS_EN
            if (acc && m_cnt < 65535) m_cnt++;
`endif
        end
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_data = '0; slot_ready = '1;
        mon_valid = '0; mon_ready = '0; drain_req = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        #2;
        checks++; if (occupancy !== 0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (err_underflow !== 0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
        checks++; if (in_ready !== 1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (drain_done !== 0 || busy !== 0) begin failures++; $display("FAIL reset_status got=%b%b exp=00", drain_done, busy); end
        checks++; if (ingest_count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ingest_count); end
        checks++; if (slot_valid !== 0) begin failures++; $display("FAIL reset_slot_valid got=%b exp=000", slot_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        for (int i = 0; i < N; i++) begin
            in_data = W'(8'hA1 + i);
            in_valid = 1;
            exp = '0;
            exp[i] = 1'b1;
            #2;
            checks++; if (slot_valid !== exp) begin failures++; $display("FAIL rr_valid%0d got=%b exp=%b", i, slot_valid, exp); end
            checks++; if (slot_data[i] !== W'(8'hA1 + i)) begin failures++; $display("FAIL rr_data%0d got=%h exp=%h", i, slot_data[i], W'(8'hA1 + i)); end
            tick();
        end
        in_valid = 0;
        #2;
        checks++; if (occupancy !== 3) begin failures++; $display("FAIL rr_full_occ got=%0d exp=3", occupancy); end
        checks++; if (in_ready !== 0) begin failures++; $display("FAIL rr_full_ready got=%b exp=0", in_ready); end
        mon_valid = '1; mon_ready = '1;
        tick();
        idle();
    endtask

    task automatic test_skip_busy();
        in_valid = 1;
        tick();
        slot_ready = 3'b101;
        #2;
        checks++; if (slot_valid !== 3'b100) begin failures++; $display("FAIL skip_valid got=%b exp=100", slot_valid); end
        tick();
        idle();
    endtask

    task automatic test_simultaneous();
        in_valid = 1; mon_valid = 3'b011; mon_ready = 3'b111;
        #2;
        checks++; if (slot_valid !== 3'b001) begin failures++; $display("FAIL simul_wrap_valid got=%b exp=001", slot_valid); end
        checks++; if (occupancy !== 2) begin failures++; $display("FAIL simul_pre_occ got=%0d exp=2", occupancy); end
        tick();
        idle();
        #2;
        checks++; if (occupancy !== 1) begin failures++; $display("FAIL simul_occ got=%0d exp=1", occupancy); end
    endtask

    task automatic test_drain();
        in_valid = 1;
        tick();
        idle();
        drain_req = 1;
        tick();
        drain_req = 0;
        #2;
        checks++; if (in_ready !== 0 || busy !== 1 || drain_done !== 0) begin failures++; $display("FAIL drain_enter got=%b%b%b exp=010", in_ready, busy, drain_done); end
        mon_valid = 3'b011; mon_ready = 3'b011;
        tick();
        idle();
        #2;
        checks++; if (drain_done !== 1 || occupancy !== 0) begin failures++; $display("FAIL drain_done got=%b occ=%0d exp=1 occ=0", drain_done, occupancy); end
        tick();
        #2;
        checks++; if (drain_done !== 0 || in_ready !== 1 || busy !== 0) begin failures++; $display("FAIL drain_exit got=%b%b%b exp=010", drain_done, in_ready, busy); end
        drain_req = 1;
        tick();
        drain_req = 0;
        #2;
        checks++; if (drain_done !== 0 || in_ready !== 0) begin failures++; $display("FAIL empty_drain_pass got=%b%b exp=00", drain_done, in_ready); end
        tick();
        #2;
        checks++; if (drain_done !== 1) begin failures++; $display("FAIL empty_drain_done got=%b exp=1", drain_done); end
        tick();
        #2;
        checks++; if (drain_done !== 0 || in_ready !== 1) begin failures++; $display("FAIL empty_drain_exit got=%b%b exp=01", drain_done, in_ready); end
    endtask

    task automatic test_underflow();
        mon_valid = 3'b001; mon_ready = 3'b001;
        tick();
        idle();
        #2;
        checks++; if (occupancy !== 0 || err_underflow !== 1) begin failures++; $display("FAIL underflow got=occ%0d err%b exp=occ0 err1", occupancy, err_underflow); end
        tick(); tick();
        #2;
        checks++; if (err_underflow !== 1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
    endtask

    task automatic test_stats();
        int exp;
        rst = 1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; mon_valid = 3'b001; mon_ready = 3'b001;
            tick();
        end
        idle();
        #2;
`ifdef CAROUSEL_SCHED_STATS_EN
        exp = 5;
`else
        exp = 0;
`endif
        checks++; if (ingest_count !== 16'(exp)) begin failures++; $display("FAIL stats_count got=%0d exp=%0d", ingest_count, exp); end
    endtask

    task automatic test_reset_mid_drain();
        in_valid = 1;
        tick(); tick();
        idle();
        mon_valid = 3'b111; mon_ready = 3'b111;
        tick();
        idle();
        drain_req = 1;
        in_valid = 1;
        tick();
        idle();
        #2;
        checks++; if (busy !== 1 || in_ready !== 0) begin failures++; $display("FAIL mid_drain_state got=%b%b exp=10", busy, in_ready); end
        rst = 1;
        tick();
        rst = 0;
        #2;
        checks++; if (in_ready !== 1 || busy !== 0 || drain_done !== 0 || occupancy !== 0 || err_underflow !== 0 || ingest_count !== 0)
            begin failures++; $display("FAIL mid_drain_reset got=rdy%b busy%b done%b occ%0d err%b cnt%0d exp=rdy1 busy0 done0 occ0 err0 cnt0",
                in_ready, busy, drain_done, occupancy, err_underflow, ingest_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = $urandom_range(0, 63) == 0;
            drain_req = $urandom_range(0, 15) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_data = W'($urandom);
            slot_ready = N'($urandom);
            mon_valid = N'($urandom & $urandom);
            mon_ready = N'($urandom | $urandom);
            #2;
            checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
            checks++; if (slot_valid !== m_valid()) begin failures++; $display("FAIL rnd_slot_valid c=%0d got=%b exp=%b", c, slot_valid, m_valid()); end
            checks++; if (occupancy !== OW'(m_occ)) begin failures++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, m_occ); end
            checks++; if (err_underflow !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_underflow, m_err); end
            checks++; if (drain_done !== (m_mode == 2)) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, drain_done, m_mode == 2); end
            checks++; if (busy !== (m_mode != 0 || m_occ != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_mode != 0 || m_occ != 0); end
            checks++; if (ingest_count !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, ingest_count, m_cnt); end
            for (int i = 0; i < N; i++) begin
                checks++; if (slot_data[i] !== in_data) begin failures++; $display("FAIL rnd_data c=%0d slot=%0d got=%h exp=%h", c, i, slot_data[i], in_data); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip_busy();
        test_simultaneous();
        test_drain();
        test_underflow();
        test_stats();
        test_reset_mid_drain();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/carousel_ingress_sched.md
CAROUSEL_INGRESS_SCHED -- requirements
Module: carousel_ingress_sched

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, payload bits per entry.
- BUFFER_SIZE, 3, number of carousel slots, minimum 2.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high. Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  WIDTH  upstream payload.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- slot_data  out  WIDTH x BUFFER_SIZE (unpacked)  per-slot payload to carousel ingest.
- slot_valid  out  1 x BUFFER_SIZE  per-slot ingest valid.
- slot_ready  in  1 x BUFFER_SIZE  per-slot empty/ready from carousel.
- mon_valid  in  1 x BUFFER_SIZE  carousel per-slot output valid (monitor).
- mon_ready  in  1 x BUFFER_SIZE  carousel per-slot output ready (monitor).
- drain_req  in  1  request to stop ingest and empty the carousel.
- drain_done  out  1  single-cycle pulse when drain completes.
- busy  out  1  state not RUN or occupancy nonzero.
- occupancy  out  $clog2(BUFFER_SIZE+1)  entries in flight.
- err_underflow  out  1  sticky occupancy-underflow flag.
- ingest_count  out  16  accepted-entry statistics counter.

Function
REQ-003 slot_data[i] SHALL equal in_data for every i (broadcast); only slot_valid qualifies it.
REQ-004 in_ready SHALL be 1 iff state==RUN, at least one slot_ready[i]==1, and occupancy<BUFFER_SIZE; it is combinational.
REQ-005 Selected slot sel SHALL be the first index with slot_ready==1, searching cyclically from rr_ptr upward and wrapping BUFFER_SIZE-1 to 0.
REQ-006 slot_valid[sel] SHALL equal in_valid && in_ready; every other slot_valid SHALL be 0; at most one slot_valid is high per cycle.
REQ-007 Accept = in_valid && in_ready; on accept, rr_ptr SHALL become (sel+1) mod BUFFER_SIZE next cycle; otherwise rr_ptr holds.
REQ-008 Dispense count d SHALL be popcount(mon_valid & mon_ready) in the same cycle.
REQ-009 Next occupancy SHALL be occupancy + accept - d; simultaneous accept and dispense are both counted in one cycle.
REQ-010 If occupancy + accept < d, occupancy SHALL saturate to 0 and err_underflow SHALL set and hold until rst.
REQ-011 The FSM SHALL have states RUN, DRAIN and DONE.
REQ-012 RUN->DRAIN SHALL occur on drain_req==1; an accept in that same cycle still completes.
REQ-013 DRAIN->DONE SHALL occur when next occupancy==0; DONE->RUN SHALL occur unconditionally after one cycle.
REQ-014 drain_req SHALL be ignored in DRAIN and DONE; in_ready SHALL be 0 in both states.
REQ-015 drain_done SHALL be 1 exactly while state==DONE.
REQ-016 drain_req in RUN with occupancy already 0 SHALL pass through DRAIN for one cycle, then DONE.
REQ-017 busy SHALL be (state!=RUN) || (occupancy!=0).
REQ-018 No accept SHALL ever occur when all slot_ready==0; this is the full condition.

Reset
REQ-019 On rst==1 at a clock edge, regardless of state or an in-flight drain, the following SHALL reset next cycle: state=RUN, rr_ptr=0, occupancy=0, err_underflow=0, ingest_count=0.
REQ-020 Outputs SHALL have no other reset dependence; slot_valid, in_ready and drain_done follow from the reset state.

Configuration
REQ-021 With macro CAROUSEL_SCHED_STATS_EN defined, ingest_count SHALL increment by 1 per accept and saturate at 16'hFFFF.
REQ-022 With CAROUSEL_SCHED_STATS_EN undefined, ingest_count SHALL be constant 0 and no counter register SHALL exist; all other behaviour is identical.

Verification (BUFFER_SIZE=3, WIDTH=8)
REQ-023 Round-robin: all slot_ready=1, 3 back-to-back accepts of 8'hA1, 8'hA2, 8'hA3 with no dispense -> slot_valid one-hot at slots 0, 1, 2; occupancy 3; then in_ready=0.
REQ-024 Skip busy slot: rr_ptr=1, slot_ready=3'b101, in_valid=1 -> slot_valid[2]=1 and rr_ptr becomes 0.
REQ-025 Simultaneous events: occupancy=2, accept plus mon_valid&mon_ready=3'b011 -> occupancy becomes 1.
REQ-026 Drain: occupancy=2, pulse drain_req -> in_ready=0 immediately next cycle; two dispenses -> drain_done high for exactly 1 cycle, then RUN and in_ready restored.
REQ-027 Underflow: occupancy=0, mon_valid&mon_ready=3'b001 -> occupancy stays 0, err_underflow=1 until rst.
REQ-028 Stats: with CAROUSEL_SCHED_STATS_EN, 5 accepts -> ingest_count=5; without it -> ingest_count=0. Reset asserted mid-DRAIN -> state RUN and all counters 0.
